// File: rtl/fast_circle_fetch_if.sv
// Bundle for fast_circle_fetch: request side, SRAM x/y read port and result handshake.
// "master" is the fetch block's view; "slave" is the view of the surrounding logic.
interface fast_circle_fetch_if #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 5,
  parameter int Y_MAX       = 5
);
  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;

  logic                        start;
  logic [XW-1:0]               cx;
  logic [YW-1:0]               cy;
  logic                        busy;
  logic signed [XW-1:0]        x_addr;
  logic signed [YW-1:0]        y_addr;
  logic                        ren;
  logic [PIXEL_DEPTH-1:0]      rdat;
  logic                        out_valid;
  logic                        out_ready;
  logic [PIXEL_DEPTH-1:0]      centre_px;
  logic [16*PIXEL_DEPTH-1:0]   ring;

  modport master (
    input  start, cx, cy, rdat, out_ready,
    output busy, x_addr, y_addr, ren, out_valid, centre_px, ring
  );

  modport slave (
    output start, cx, cy, rdat, out_ready,
    input  busy, x_addr, y_addr, ren, out_valid, centre_px, ring
  );
endinterface

// File: rtl/fast_circle_fetch.sv
// Issues the 17 SRAM reads (centre + radius-3 ring) for a FAST corner candidate,
// captures the one-cycle-latency read data and hands the packed result out on valid/ready.
module fast_circle_fetch #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 5,
  parameter int Y_MAX       = 5
) (
  input  logic                  clk,
  input  logic                  n_rst,
  fast_circle_fetch_if.master   bus
);
  localparam int XW  = $clog2(X_MAX) + 1;
  localparam int YW  = $clog2(Y_MAX) + 1;
  localparam int CXW = XW + 2;
  localparam int CYW = YW + 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

  state_t                     state_q;
  logic [XW-1:0]              cx_q;
  logic [YW-1:0]              cy_q;
  logic [4:0]                 slot_q;
  logic [4:0]                 cap_slot_q;
  logic                       cap_en_q;
  logic                       cap_inb_q;
  logic                       busy_q;
  logic                       out_valid_q;
  logic [PIXEL_DEPTH-1:0]     centre_q;
  logic [16*PIXEL_DEPTH-1:0]  ring_q;

  logic signed [CXW-1:0]      dx, px;
  logic signed [CYW-1:0]      dy, py;
  logic                       inb;
  logic [PIXEL_DEPTH-1:0]     cap_px;

  always_comb begin
    dx = '0;
    dy = '0;
    case (slot_q)
      5'd1:    begin dx = CXW'( 0); dy = CYW'(-3); end
      5'd2:    begin dx = CXW'( 1); dy = CYW'(-3); end
      5'd3:    begin dx = CXW'( 2); dy = CYW'(-2); end
      5'd4:    begin dx = CXW'( 3); dy = CYW'(-1); end
      5'd5:    begin dx = CXW'( 3); dy = CYW'( 0); end
      5'd6:    begin dx = CXW'( 3); dy = CYW'( 1); end
      5'd7:    begin dx = CXW'( 2); dy = CYW'( 2); end
      5'd8:    begin dx = CXW'( 1); dy = CYW'( 3); end
      5'd9:    begin dx = CXW'( 0); dy = CYW'( 3); end
      5'd10:   begin dx = CXW'(-1); dy = CYW'( 3); end
      5'd11:   begin dx = CXW'(-2); dy = CYW'( 2); end
      5'd12:   begin dx = CXW'(-3); dy = CYW'( 1); end
      5'd13:   begin dx = CXW'(-3); dy = CYW'( 0); end
      5'd14:   begin dx = CXW'(-3); dy = CYW'(-1); end
      5'd15:   begin dx = CXW'(-2); dy = CYW'(-2); end
      5'd16:   begin dx = CXW'(-1); dy = CYW'(-3); end
      default: begin dx = '0;       dy = '0;       end
    endcase

    // Two guard bits keep the sum from wrapping, so the sign bit alone flags x<0 / y<0.
    px  = $signed({2'b00, cx_q}) + dx;
    py  = $signed({2'b00, cy_q}) + dy;
    inb = !px[CXW-1] && (px <= CXW'(X_MAX - 1)) &&
          !py[CYW-1] && (py <= CYW'(Y_MAX - 1));

    bus.ren    = (state_q == FETCH) && inb;
    bus.x_addr = bus.ren ? px[XW-1:0] : '0;
    bus.y_addr = bus.ren ? py[YW-1:0] : '0;

    cap_px = cap_inb_q ? bus.rdat : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      slot_q      <= '0;
      cap_slot_q  <= '0;
      cap_en_q    <= 1'b0;
      cap_inb_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      centre_q    <= '0;
      ring_q      <= '0;
    end else begin
      cap_en_q   <= (state_q == FETCH);
      cap_slot_q <= slot_q;
      cap_inb_q  <= inb;

      if (cap_en_q) begin
        if (cap_slot_q == 5'd0) centre_q <= cap_px;
        else ring_q[(int'(cap_slot_q) - 1) * PIXEL_DEPTH +: PIXEL_DEPTH] <= cap_px;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cx_q    <= bus.cx;
            cy_q    <= bus.cy;
            slot_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (slot_q == 5'd16) state_q <= DRAIN;
          else                 slot_q  <= slot_q + 5'd1;
        end
        DRAIN: begin
          out_valid_q <= 1'b1;
          state_q     <= VALID;
        end
        VALID: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.centre_px = centre_q;
  assign bus.ring      = ring_q;
endmodule

// File: tb/tb_fast_circle_fetch.sv
// Drives an 8x8 and a 5x5 instance with identical requests, each backed by its own SRAM model,
// and compares every cycle against a geometric model of the FAST circle fetch.
module tb_fast_circle_fetch;
  logic       clk = 1'b0;
  logic       n_rst;
  logic       start, out_ready;
  logic [3:0] cx, cy;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic [7:0] img [0:7][0:7];
  int DX [16] = '{ 0, 1, 2, 3, 3, 3, 2, 1, 0,-1,-2,-3,-3,-3,-2,-1};
  int DY [16] = '{-3,-3,-2,-1, 0, 1, 2, 3, 3, 3, 2, 1, 0,-1,-2,-3};

  always #5 clk = ~clk;

  fast_circle_fetch_if #(.PIXEL_DEPTH(8), .X_MAX(8), .Y_MAX(8)) ba ();
  fast_circle_fetch_if #(.PIXEL_DEPTH(8), .X_MAX(5), .Y_MAX(5)) bb ();

  fast_circle_fetch #(.PIXEL_DEPTH(8), .X_MAX(8), .Y_MAX(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(ba.master));
  fast_circle_fetch #(.PIXEL_DEPTH(8), .X_MAX(5), .Y_MAX(5)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bb.master));

  assign ba.start = start;     assign bb.start = start;
  assign ba.cx = cx;           assign bb.cx = cx;
  assign ba.cy = cy;           assign bb.cy = cy;
  assign ba.out_ready = out_ready;
  assign bb.out_ready = out_ready;

  // SRAM models: one-cycle read latency, garbage on the bus whenever no read was issued.
  always @(posedge clk) begin
    ba.rdat <= ba.ren ? img[ba.y_addr[2:0]][ba.x_addr[2:0]] : 8'($urandom);
    bb.rdat <= bb.ren ? img[bb.y_addr[2:0]][bb.x_addr[2:0]] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int slot_x(int c, int s);
    return (s == 0) ? c : c + DX[s-1];
  endfunction
  function automatic int slot_y(int c, int s);
    return (s == 0) ? c : c + DY[s-1];
  endfunction
  function automatic bit in_img(int c_x, int c_y, int s, int xm, int ym);
    int x = slot_x(c_x, s);
    int y = slot_y(c_y, s);
    return (x >= 0) && (x < xm) && (y >= 0) && (y < ym);
  endfunction
  function automatic logic [7:0] model_px(int c_x, int c_y, int s, int xm, int ym);
    if (!in_img(c_x, c_y, s, xm, ym)) return 8'h00;
    return img[slot_y(c_y, s)][slot_x(c_x, s)];
  endfunction
  function automatic logic [127:0] model_ring(int c_x, int c_y, int xm, int ym);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = model_px(c_x, c_y, k + 1, xm, ym);
    return r;
  endfunction
  function automatic int model_reads(int c_x, int c_y, int xm, int ym);
    int n = 0;
    for (int s = 0; s < 17; s++) if (in_img(c_x, c_y, s, xm, ym)) n++;
    return n;
  endfunction

  // Address hygiene on every cycle, independent of the sequence being run.
  always @(negedge clk) begin
    if (ba.ren) check("bounds_a", {30'd0, int'(ba.x_addr) >= 0 && int'(ba.x_addr) < 8,
                                          int'(ba.y_addr) >= 0 && int'(ba.y_addr) < 8}, 2'b11);
    else        check("idle_addr_a", {ba.x_addr, ba.y_addr}, 0);
    if (bb.ren) check("bounds_b", {30'd0, int'(bb.x_addr) >= 0 && int'(bb.x_addr) < 5,
                                          int'(bb.y_addr) >= 0 && int'(bb.y_addr) < 5}, 2'b11);
    else        check("idle_addr_b", {bb.x_addr, bb.y_addr}, 0);
  end

  task automatic check_result(input int cxv, input int cyv);
    check("centre_a", ba.centre_px, model_px(cxv, cyv, 0, 8, 8));
    check("ring_a",   ba.ring,      model_ring(cxv, cyv, 8, 8));
    check("centre_b", bb.centre_px, model_px(cxv, cyv, 0, 5, 5));
    check("ring_b",   bb.ring,      model_ring(cxv, cyv, 5, 5));
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the handshake.
  task automatic run_fetch(input int cxv, input int cyv, input int hold,
                           input bit poke_busy, input bit poke_valid,
                           input bit poke_done, input bit ready_early);
    int na = 0, nb = 0;
    bit ea, eb;
    out_ready = ready_early;
    start = 1'b1; cx = 4'(cxv); cy = 4'(cyv);
    @(negedge clk);
    cx = 4'(cxv ^ 3); cy = 4'(cyv ^ 5);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) @(negedge clk);
      ea = (c <= 17) && in_img(cxv, cyv, c - 1, 8, 8);
      eb = (c <= 17) && in_img(cxv, cyv, c - 1, 5, 5);
      check("ren_a", ba.ren, ea);
      check("ren_b", bb.ren, eb);
      if (ba.ren) na++;
      if (bb.ren) nb++;
      if (ea) check("addr_a", {ba.x_addr, ba.y_addr},
                    {4'(slot_x(cxv, c - 1)), 4'(slot_y(cyv, c - 1))});
      if (eb) check("addr_b", {bb.x_addr, bb.y_addr},
                    {4'(slot_x(cxv, c - 1)), 4'(slot_y(cyv, c - 1))});
      check("valid", {ba.out_valid, bb.out_valid}, (c == 19) ? 2'b11 : 2'b00);
      check("busy", {ba.busy, bb.busy}, 2'b11);
      start = poke_busy && (c == 5 || c == 9);
    end
    check("reads_a", na, model_reads(cxv, cyv, 8, 8));
    check("reads_b", nb, model_reads(cxv, cyv, 5, 5));
    check_result(cxv, cyv);
    for (int i = 0; i < hold; i++) begin
      start = poke_valid && (i == hold / 2);
      @(negedge clk);
      check("hold_valid", {ba.out_valid, bb.out_valid}, 2'b11);
      check_result(cxv, cyv);
    end
    out_ready = 1'b1;
    start = poke_done;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("done_valid", {ba.out_valid, bb.out_valid, ba.busy, bb.busy}, 4'b0000);
    check_result(cxv, cyv);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; cx = '0; cy = '0; out_ready = 1'b0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 8'(16 * y + x);
    repeat (2) @(negedge clk);
    check("rst_ctrl", {ba.busy, ba.ren, ba.out_valid, bb.busy, bb.ren, bb.out_valid}, 0);
    check("rst_data", {ba.centre_px, bb.centre_px}, 0);
    n_rst = 1'b1;
    @(negedge clk);

    run_fetch(3, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d1_centre", ba.centre_px, 8'h33);
    check("d1_ring",   {ba.ring[0+:8], ba.ring[32+:8], ba.ring[64+:8], ba.ring[96+:8], ba.ring[16+:8]},
                       40'h03_36_63_30_15);

    run_fetch(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("d2_centre", ba.centre_px, 8'h00);
    check("d2_ring",   {ba.ring[32+:8], ba.ring[48+:8], ba.ring[64+:8]}, 24'h03_22_30);

    run_fetch(5, 2, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    check("d3_idle", {ba.busy, bb.busy, ba.ren, bb.ren}, 4'b0000);
    run_fetch(1, 6, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while slot 8 is on the bus.
    start = 1'b1; cx = 4'd2; cy = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mrst_ctrl_a", {ba.busy, ba.ren, ba.x_addr, ba.y_addr, ba.out_valid}, 0);
    check("mrst_ctrl_b", {bb.busy, bb.ren, bb.x_addr, bb.y_addr, bb.out_valid}, 0);
    check("mrst_data_a", {ba.centre_px, ba.ring}, 0);
    check("mrst_data_b", {bb.centre_px, bb.ring}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    run_fetch(4, 4, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d5_a", {ba.centre_px, ba.ring[0+:8]}, 16'h44_14);
    check("d5_b", {bb.ring[96+:8], bb.ring[0+:8]}, 16'h41_14);

    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 8'($urandom);
    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 5)
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 8; x++) img[y][x] = 8'($urandom);
      run_fetch(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fast_circle_fetch.md
# fast_circle_fetch

Read initiator for the image SRAM: given a candidate centre pixel (cx, cy), it issues the 17 pixel reads needed by the FAST corner test. These are the centre plus the 16-point radius-3 Bresenham ring. It captures the one-cycle-latency read data and presents the results as one packed vector on a valid/ready output. It sits between the corner-scan controller (upstream) and the image SRAM's x/y read port; the SRAM's write enable is tied low at the top level when this block owns the port.

## Interface
- PIXEL_DEPTH, 8, bits per pixel
- X_MAX, 5, image width in pixels
- Y_MAX, 5, image height in pixels
- clk  in  1  single clock; drives both this block and the SRAM
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  request a fetch; accepted only in IDLE
- cx  in  $clog2(X_MAX)+1  centre x, unsigned, sampled on the accepting edge
- cy  in  $clog2(Y_MAX)+1  centre y, unsigned, sampled on the accepting edge
- busy  out  1  high in every state other than IDLE
- x_addr  out  $clog2(X_MAX)+1 (signed)  SRAM x address
- y_addr  out  $clog2(Y_MAX)+1 (signed)  SRAM y address
- ren  out  1  SRAM read enable
- rdat  in  PIXEL_DEPTH  SRAM read data, valid the cycle after ren
- out_valid  out  1  centre_px and ring are valid
- out_ready  in  1  consumer accepts the result
- centre_px  out  PIXEL_DEPTH  centre pixel
- ring  out  16*PIXEL_DEPTH  ring pixels; index k occupies bits [k*PIXEL_DEPTH +: PIXEL_DEPTH]

## Operation
- Slot order: slot 0 = centre (0,0); slots 1..16 = ring k=0..15.
- Ring offsets (dx,dy), k = 0..15: (0,-3) (1,-3) (2,-2) (3,-1) (3,0) (3,1) (2,2) (1,3) (0,3) (-1,3) (-2,2) (-3,1) (-3,0) (-3,-1) (-2,-2) (-1,-3).
- Coordinate arithmetic: coordinates are computed signed, with 2 bits beyond the port width so there is no wrap.
- A slot is out of bounds (OOB) if x<0, x>X_MAX-1, y<0 or y>Y_MAX-1.
- In-bounds slot: ren=1 and x_addr/y_addr carry the truncated coordinates.
- OOB slot: ren=0, x_addr=y_addr=0, and the stored pixel is forced to 0. The SRAM is never addressed out of bounds.
- States:
  - IDLE: start=1 → latch cx/cy, clear slot counter, go to FETCH.
  - FETCH: one slot per cycle, counter 0..16. After slot 16 → DRAIN.
  - DRAIN: capture the last slot → VALID.
  - VALID: out_valid=1; out_valid & out_ready → IDLE.
- Capture pipeline: a 1-cycle delayed copy of {slot index, in-bounds flag}.
  - At each edge with the delayed flag set, rdat is written to that slot's register.
  - With the flag clear, 0 is written instead.
  - rdat is never sampled in a cycle where the previous ren was 0.
- start while busy is ignored; it is not queued.
- Result registers are stable and unchanged throughout VALID. They are overwritten only by the next fetch.

## Timing
- Reset (n_rst low, any state, including mid-fetch): IDLE, busy=0, ren=0, x_addr=0, y_addr=0, out_valid=0, centre_px=0, ring=0, counters cleared. Any in-flight read data is discarded.
- Edge E0 accepts start. Slot s is presented combinationally from FETCH state during cycle s+1 and sampled by the SRAM at edge E(s+1).
- Slot s data is captured at edge E(s+2).
- Slot 16 is issued at E17 and captured at E18. out_valid rises after E18: 18 cycles from start to valid.
- The handshake completes at the first edge with out_valid & out_ready; out_valid is low after that edge.
- The earliest next start is accepted at the edge after return to IDLE; start in the completing cycle is ignored. Minimum period is 20 cycles.
- out_ready held high before VALID has no effect.
- ren is high for at most 17 cycles per fetch and never in IDLE, DRAIN or VALID.

## Test plan
- X_MAX=Y_MAX=8, pixel(x,y)=16y+x, start with cx=3, cy=3 → ren high for 17 consecutive cycles. Then, 18 cycles after start: centre_px=0x33, ring[0]=0x03, ring[4]=0x36, ring[8]=0x63, ring[12]=0x30, ring[2]=0x15.
- Same image, cx=0, cy=0 → ren high only for slots 0 and k=4..8 (6 cycles).
  - OOB slots drive address 0.
  - centre_px=0x00, ring[4]=0x03, ring[6]=0x22, ring[8]=0x30.
  - ring[0..3] and ring[9..15] are all 0.
- Backpressure: out_ready held low for 10 cycles after valid → out_valid and all outputs stable. Pulse out_ready → out_valid=0 next cycle; start pulsed during VALID is ignored.
- start pulsed at cycles 5 and 9 of a fetch → no extra ren and no corruption. The result matches the first request.
- n_rst asserted during slot 8, then start with cx=4, cy=4 → all outputs 0 during reset. The new result equals a clean fetch: centre_px=0x44, ring[0]=0x14.
- X_MAX=Y_MAX=5 default, cx=4, cy=4 → every ring slot with x>4 or y>4 reads 0 with ren low. ring[12]=pixel(1,4), ring[0]=pixel(4,1).
